// File: rtl/wb_arb_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
// Pairs a writeback request with the one-hot helper used for the pending-destination mask.
package wb_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_e;

  // x0 is never a real destination, so it never shows up as pending.
  function automatic logic [XLEN-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [XLEN-1:0] oh;
    oh     = '0;
    oh[rd] = (rd != '0);
    return oh;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small circular buffer holding mul/div results until the write port is free.
// Exposes per-slot valid bits and destinations so the parent can build a pending mask.
module wb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  push_i,
  input  wb_req_t                               data_i,
  input  logic                                  pop_i,
  output wb_req_t                               head_o,
  output logic [$clog2(DEPTH+1)-1:0]            count_o,
  output logic                                  full_o,
  output logic                                  empty_o,
  output logic [DEPTH-1:0]                      valid_o,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]      entry_rd_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  wb_req_t [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic                do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign valid_o = valid_q;

  always_comb begin
    valid_d = valid_q;
    count_d = count_q;
    if (do_pop) valid_d[rd_ptr_q] = 1'b0;
    if (do_push) valid_d[wr_ptr_q] = 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_rd_o[i] = mem_q[i].rd;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares register-file write port 3 between the W stage and buffered mul/div results.
// The pipeline wins by default; an aging counter or a blocked full buffer forces a one-cycle stall to drain.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  RegWriteW_i,
  input  logic [REG_ADDR_W-1:0] RdW_i,
  input  logic [XLEN-1:0]       ResultW_i,
  input  logic                  md_valid_i,
  output logic                  md_ready_o,
  input  logic [REG_ADDR_W-1:0] md_rd_i,
  input  logic [XLEN-1:0]       md_result_i,
  output logic                  RegWrite_o,
  output logic [REG_ADDR_W-1:0] Rd_o,
  output logic [XLEN-1:0]       WD_o,
  output logic                  StallW_o,
  output logic [XLEN-1:0]       rd_pending_o
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  arb_state_e                     state_q, state_d;
  logic [WAIT_W-1:0]              wait_q, wait_d;
  logic                           stall_q;

  wb_req_t                        fifo_head;
  logic [CNT_W-1:0]               fifo_count;
  logic                           fifo_full, fifo_empty;
  logic [DEPTH-1:0]               fifo_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] fifo_rd;

  logic                           pipe_req, push, pop;
  logic                           grant_we;
  logic [REG_ADDR_W-1:0]          grant_rd;
  logic [XLEN-1:0]                grant_wd;

  assign pipe_req   = RegWriteW_i && (RdW_i != '0);
  assign md_ready_o = (fifo_count < CNT_W'(DEPTH)) && rst_ni;
  assign push       = md_valid_i && md_ready_o;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (push),
    .data_i     ('{rd: md_rd_i, data: md_result_i}),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .valid_o    (fifo_valid),
    .entry_rd_o (fifo_rd)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= NORMAL;
      wait_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= (state_d == FORCE);
    end
  end

  // The head ages only while it sits behind pipeline writes; any pop restarts the count.
  always_comb begin
    state_d = NORMAL;
    wait_d  = '0;
    if (state_q == NORMAL) begin
      if (!fifo_empty && !pop) begin
        wait_d = (wait_q == WAIT_W'(MAX_WAIT)) ? wait_q : wait_q + WAIT_W'(1);
      end
      if ((wait_d == WAIT_W'(MAX_WAIT)) || (pipe_req && fifo_full && md_valid_i)) begin
        state_d = FORCE;
      end
    end
  end

  always_comb begin
    pop      = 1'b0;
    grant_we = 1'b0;
    grant_rd = '0;
    grant_wd = '0;
    if (state_q == FORCE) begin
      pop = !fifo_empty;
    end else if (pipe_req) begin
      grant_we = 1'b1;
      grant_rd = RdW_i;
      grant_wd = ResultW_i;
    end else begin
      pop = !fifo_empty;
    end
    if (pop) begin
      grant_we = (fifo_head.rd != '0);
      grant_rd = fifo_head.rd;
      grant_wd = fifo_head.data;
    end
  end

  // The pipeline path is combinational from the inputs, so reset must mask it explicitly.
  assign RegWrite_o = grant_we && rst_ni;
  assign Rd_o       = rst_ni ? grant_rd : '0;
  assign WD_o       = rst_ni ? grant_wd : '0;
  assign StallW_o   = stall_q;

  always_comb begin
    rd_pending_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_valid[i]) rd_pending_o = rd_pending_o | rd_onehot(fifo_rd[i]);
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a queue-based reference model checked every cycle,
// plus hand-pinned literal expectations for the key scenarios.
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  localparam int F_WE    = 0;
  localparam int F_RD    = 1;
  localparam int F_WD    = 2;
  localparam int F_STALL = 3;
  localparam int F_READY = 4;
  localparam int F_PEND  = 5;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        RegWriteW_i;
  logic [4:0]  RdW_i;
  logic [31:0] ResultW_i;
  logic        md_valid_i;
  logic        md_ready_o;
  logic [4:0]  md_rd_i;
  logic [31:0] md_result_i;
  logic        RegWrite_o;
  logic [4:0]  Rd_o;
  logic [31:0] WD_o;
  logic        StallW_o;
  logic [31:0] rd_pending_o;

  int vectorsApplied = 0;
  int miscompares = 0;

  logic [5:0]  litOn = '0;
  logic [31:0] litExp [6];

  wb_req_t     modelQ[$];
  int          waitCnt;
  logic        inForce;
  logic        pendPush, pendPop, pendForce;
  int          pendWait;
  wb_req_t     pendEntry;
  logic        pipeReq, popNow;
  logic [31:0] expV [6];
  logic [31:0] actV [6];

  wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .RegWriteW_i  (RegWriteW_i),
    .RdW_i        (RdW_i),
    .ResultW_i    (ResultW_i),
    .md_valid_i   (md_valid_i),
    .md_ready_o   (md_ready_o),
    .md_rd_i      (md_rd_i),
    .md_result_i  (md_result_i),
    .RegWrite_o   (RegWrite_o),
    .Rd_o         (Rd_o),
    .WD_o         (WD_o),
    .StallW_o     (StallW_o),
    .rd_pending_o (rd_pending_o)
  );

  initial forever #5 clk = ~clk;

  function automatic string fieldName(input int f);
    case (f)
      F_WE:    return "RegWrite_o";
      F_RD:    return "Rd_o";
      F_WD:    return "WD_o";
      F_STALL: return "StallW_o";
      F_READY: return "md_ready_o";
      default: return "rd_pending_o";
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  // Reference model: the buffer is a plain queue; decisions made this cycle take effect at the next check.
  always begin
    @(negedge clk or negedge rst_ni);
    #1;
    actV[F_WE]    = 32'(RegWrite_o);
    actV[F_RD]    = 32'(Rd_o);
    actV[F_WD]    = WD_o;
    actV[F_STALL] = 32'(StallW_o);
    actV[F_READY] = 32'(md_ready_o);
    actV[F_PEND]  = rd_pending_o;
    for (int f = 0; f < 6; f++) expV[f] = '0;
    if (!rst_ni) begin
      modelQ.delete();
      waitCnt   = 0;
      inForce   = 1'b0;
      pendPush  = 1'b0;
      pendPop   = 1'b0;
      pendForce = 1'b0;
      pendWait  = 0;
    end else begin
      if (pendPop && modelQ.size() > 0) void'(modelQ.pop_front());
      if (pendPush) modelQ.push_back(pendEntry);
      waitCnt = pendWait;
      inForce = pendForce;

      pipeReq = RegWriteW_i && (RdW_i != 5'd0);
      popNow  = 1'b0;
      if (inForce) begin
        expV[F_STALL] = 32'd1;
        popNow = (modelQ.size() > 0);
      end else if (pipeReq) begin
        expV[F_WE] = 32'd1;
        expV[F_RD] = 32'(RdW_i);
        expV[F_WD] = ResultW_i;
      end else begin
        popNow = (modelQ.size() > 0);
      end
      if (popNow) begin
        expV[F_WE] = 32'(modelQ[0].rd != 5'd0);
        expV[F_RD] = 32'(modelQ[0].rd);
        expV[F_WD] = modelQ[0].data;
      end
      expV[F_READY] = 32'(modelQ.size() < DEPTH);
      foreach (modelQ[k]) begin
        if (modelQ[k].rd != 5'd0) expV[F_PEND][modelQ[k].rd] = 1'b1;
      end

      pendPop   = popNow;
      pendPush  = md_valid_i && (modelQ.size() < DEPTH);
      pendEntry = '{rd: md_rd_i, data: md_result_i};
      if (inForce) begin
        pendWait  = 0;
        pendForce = 1'b0;
      end else begin
        if (popNow || modelQ.size() == 0) pendWait = 0;
        else pendWait = (waitCnt + 1 > MAX_WAIT) ? MAX_WAIT : waitCnt + 1;
        pendForce = (pendWait == MAX_WAIT) ||
                    (pipeReq && modelQ.size() == DEPTH && md_valid_i);
      end
    end
    for (int f = 0; f < 6; f++) checkOutput(fieldName(f), actV[f], expV[f]);
    for (int f = 0; f < 6; f++) begin
      if (litOn[f]) checkOutput({"pinned ", fieldName(f)}, actV[f], litExp[f]);
    end
  end

  task automatic applyStimulus(input logic we, input logic [4:0] rdw, input logic [31:0] resw,
                               input logic mv, input logic [4:0] mrd, input logic [31:0] mres);
    @(posedge clk);
    #1;
    RegWriteW_i = we;
    RdW_i       = rdw;
    ResultW_i   = resw;
    md_valid_i  = mv;
    md_rd_i     = mrd;
    md_result_i = mres;
    litOn       = '0;
  endtask

  task automatic expectLit(input int field, input logic [31:0] value);
    litOn[field]  = 1'b1;
    litExp[field] = value;
  endtask

  task automatic expectAllZero();
    for (int f = 0; f < 6; f++) expectLit(f, 32'd0);
  endtask

  task automatic idleInputs();
    RegWriteW_i = 1'b0;
    RdW_i       = '0;
    ResultW_i   = '0;
    md_valid_i  = 1'b0;
    md_rd_i     = '0;
    md_result_i = '0;
  endtask

  initial begin
    idleInputs();
    expectAllZero();
    repeat (2) @(negedge clk);
    #3;
    rst_ni = 1'b1;

    // Idle pipeline: a pushed result is written the next cycle.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h1234);
    expectLit(F_READY, 32'd1); expectLit(F_WE, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expectLit(F_WE, 32'd1); expectLit(F_RD, 32'd5); expectLit(F_WD, 32'h1234);
    expectLit(F_PEND, 32'h20);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expectLit(F_WE, 32'd0); expectLit(F_PEND, 32'd0);

    // Continuous pipeline writes: four grants to the pipeline, then one forced drain.
    applyStimulus(1'b1, 5'd3, 32'hAAAA0003, 1'b1, 5'd7, 32'h77);
    expectLit(F_WE, 32'd1); expectLit(F_RD, 32'd3);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 5'd3, 32'hAAAA0003, 1'b0, 5'd0, 32'h0);
      expectLit(F_RD, 32'd3); expectLit(F_STALL, 32'd0); expectLit(F_PEND, 32'h80);
    end
    applyStimulus(1'b1, 5'd3, 32'hAAAA0003, 1'b0, 5'd0, 32'h0);
    expectLit(F_STALL, 32'd1); expectLit(F_RD, 32'd7); expectLit(F_WD, 32'h77); expectLit(F_WE, 32'd1);
    applyStimulus(1'b1, 5'd3, 32'hAAAA0003, 1'b0, 5'd0, 32'h0);
    expectLit(F_STALL, 32'd0); expectLit(F_RD, 32'd3); expectLit(F_PEND, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Full buffer with a blocked producer forces a drain, then the third push lands.
    applyStimulus(1'b1, 5'd3, 32'h3333, 1'b1, 5'd9, 32'h99);
    applyStimulus(1'b1, 5'd3, 32'h3333, 1'b1, 5'd10, 32'hA0);
    expectLit(F_READY, 32'd1);
    applyStimulus(1'b1, 5'd3, 32'h3333, 1'b1, 5'd11, 32'hB0);
    expectLit(F_READY, 32'd0); expectLit(F_STALL, 32'd0);
    applyStimulus(1'b1, 5'd3, 32'h3333, 1'b1, 5'd11, 32'hB0);
    expectLit(F_STALL, 32'd1); expectLit(F_READY, 32'd0); expectLit(F_RD, 32'd9);
    applyStimulus(1'b1, 5'd3, 32'h3333, 1'b1, 5'd11, 32'hB0);
    expectLit(F_READY, 32'd1); expectLit(F_STALL, 32'd0); expectLit(F_RD, 32'd3);
    applyStimulus(1'b1, 5'd3, 32'h3333, 1'b0, 5'd0, 32'h0);
    expectLit(F_PEND, 32'h0000_0C00);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expectLit(F_RD, 32'd10); expectLit(F_WD, 32'hA0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expectLit(F_RD, 32'd11); expectLit(F_WD, 32'hB0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expectLit(F_PEND, 32'd0); expectLit(F_WE, 32'd0);

    // x0 handling: a pipeline write to x0 yields the port; an rd=0 entry pops silently.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC0);
    applyStimulus(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hEE);
    expectLit(F_WE, 32'd1); expectLit(F_RD, 32'd12); expectLit(F_WD, 32'hC0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expectLit(F_WE, 32'd0); expectLit(F_RD, 32'd0); expectLit(F_WD, 32'hEE); expectLit(F_PEND, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expectLit(F_WE, 32'd0); expectLit(F_WD, 32'd0);

    // Push and pop on the same edge keep one entry buffered.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 32'h14);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd21, 32'h15);
    expectLit(F_RD, 32'd20); expectLit(F_READY, 32'd1); expectLit(F_PEND, 32'h0010_0000);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expectLit(F_RD, 32'd21); expectLit(F_WD, 32'h15); expectLit(F_PEND, 32'h0020_0000);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expectLit(F_WE, 32'd0); expectLit(F_PEND, 32'd0);

    // Reset pulse while in FORCE with two buffered entries.
    applyStimulus(1'b1, 5'd3, 32'h3333, 1'b1, 5'd1, 32'h11);
    applyStimulus(1'b1, 5'd3, 32'h3333, 1'b1, 5'd2, 32'h22);
    applyStimulus(1'b1, 5'd3, 32'h3333, 1'b1, 5'd4, 32'h44);
    expectLit(F_READY, 32'd0);
    applyStimulus(1'b1, 5'd3, 32'h3333, 1'b0, 5'd0, 32'h0);
    expectLit(F_STALL, 32'd1); expectLit(F_RD, 32'd1); expectLit(F_PEND, 32'h6);
    @(negedge clk);
    #2;
    rst_ni = 1'b0;
    idleInputs();
    litOn = '0;
    expectAllZero();
    #2;
    rst_ni = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expectLit(F_WE, 32'd0); expectLit(F_PEND, 32'd0); expectLit(F_READY, 32'd1); expectLit(F_STALL, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expectLit(F_WE, 32'd1); expectLit(F_RD, 32'd6); expectLit(F_WD, 32'h66); expectLit(F_PEND, 32'h40);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expectLit(F_WE, 32'd0);

    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the pipeline writeback stage and an out-of-band multi-cycle unit (mul/div) whose results return asynchronously to the pipeline. Pipeline writes have priority. Mul/div results wait in a small FIFO, and an aging counter forces a one-cycle pipeline stall so buffered results cannot starve. Sits between the W-stage result mux and register-file write port 3. It exports a pending-destination mask for the hazard unit.

## Interface
- `DEPTH`, 2: mul/div result FIFO entries (power of two, ≥2).
- `MAX_WAIT`, 4: cycles a non-empty FIFO head may wait before a forced drain (≥1).
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `RegWriteW_i` in 1: W stage requests a register write.
- `RdW_i` in 5: W stage destination.
- `ResultW_i` in 32: W stage result (output of the writeback mux).
- `md_valid_i` in 1: mul/div result valid.
- `md_ready_o` out 1: arbiter can accept a mul/div result.
- `md_rd_i` in 5: mul/div destination.
- `md_result_i` in 32: mul/div result.
- `RegWrite_o` out 1: register-file write enable.
- `Rd_o` out 5: register-file write address.
- `WD_o` out 32: register-file write data.
- `StallW_o` out 1: pipeline must hold W and earlier stages this cycle (registered).
- `rd_pending_o` out 32: bit n set while any FIFO entry targets xn (bit 0 always 0).

## Operation
- **Push.** A mul/div transfer occurs on a rising edge with `md_valid_i && md_ready_o`. `md_ready_o = (count < DEPTH) && rst_ni`. It depends on count only; no push-through-pop when full.
- **x0 entries.** An entry with rd=0 is accepted. When it reaches the head it is popped in the next non-pipeline cycle without asserting `RegWrite_o`.
- **FSM states:** NORMAL, FORCE.
- **NORMAL grant rules:**
  - `pipe_req = RegWriteW_i && RdW_i != 0`. If `pipe_req`, grant the pipeline: `RegWrite_o=1`, `Rd_o=RdW_i`, `WD_o=ResultW_i`. No pop.
  - Else if the FIFO is non-empty, grant the head: `RegWrite_o=(head.rd!=0)`, `Rd_o/WD_o` from head, pop.
  - Else `RegWrite_o=0`, `Rd_o=0`, `WD_o=0`.
- **Aging counter.**
  - `wait_cnt` (clog2(MAX_WAIT+1) bits) increments each NORMAL cycle the FIFO is non-empty and the head is not popped.
  - It clears on any pop or when the FIFO is empty.
  - It saturates at MAX_WAIT.
- **NORMAL → FORCE** on the edge where the next `wait_cnt` equals MAX_WAIT, or where `pipe_req && count==DEPTH && md_valid_i`. The second case is a full FIFO with a blocked producer.
- **FORCE**, exactly one cycle:
  - `StallW_o=1`.
  - The head is granted and popped regardless of `pipe_req`. The pipeline holds its W request stable and it is written in a later cycle.
  - `wait_cnt` clears.
  - Next state is NORMAL. FORCE is never entered with an empty FIFO.
- **Simultaneous push and pop** in one cycle: count unchanged. A pushed entry is never popped in its push cycle.
- **Pending mask.** `rd_pending_o` is the OR of one-hot(rd) over valid entries. It updates on the edge after push or pop.
- **Reset.** Asynchronous assertion, mid-operation included, immediately:
  - empties the FIFO (entries discarded);
  - sets state NORMAL and `wait_cnt=0`;
  - drives `StallW_o=0`, `md_ready_o=0`, `RegWrite_o=0`, `Rd_o=0`, `WD_o=0`, `rd_pending_o=0`.

## Timing
- Pipeline write is combinational: `RegWriteW_i` to `RegWrite_o` within the same cycle. The register file commits on the next rising edge.
- Mul/div minimum latency: accepted at edge t, earliest write-port grant in cycle t→t+1.
- `StallW_o` is a flop output asserted in the FORCE cycle only.
- Worst-case head wait: MAX_WAIT cycles plus the FORCE cycle.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH+1).

## Structure
- Package `wb_arb_pkg` holds:
  - `wb_req_t` struct {rd[4:0], data[31:0]};
  - `arb_state_e` enum {NORMAL, FORCE};
  - `REG_ADDR_W=5` and `XLEN=32`.
- Sub-module `wb_fifo` (parameter DEPTH, payload `wb_req_t`) provides push/pop, head, count, full, empty and an entry-valid vector for the mask.
- The arbiter top holds the FSM, `wait_cnt`, grant mux and mask OR-reduction.

## Test plan
- **Idle pipeline.** Push {rd=5, 0x1234}, `RegWriteW_i=0`. Next cycle: `RegWrite_o=1`, `Rd_o=5`, `WD_o=0x1234`. `rd_pending_o` bit 5 is set one cycle, then clear.
- **Continuous pipeline writes.** `RegWriteW_i=1`, `RdW_i=3` every cycle; one md push {rd=7}.
  - Pipeline is granted for 4 cycles (MAX_WAIT=4).
  - Then one FORCE cycle: `StallW_o=1`, write rd=7.
  - Pipeline rd=3 is written the cycle after.
- **Full FIFO.** Push 2 entries while the pipeline writes continuously and a third `md_valid_i` is held.
  - `md_ready_o=0`, FORCE is entered next edge, one entry pops.
  - `md_ready_o=1` the following cycle and the third push is accepted.
- **x0 handling.** Pipeline write to x0 with a non-empty FIFO: FIFO head is granted that cycle. A FIFO entry rd=0 pops with `RegWrite_o=0`.
- **Reset mid-operation.** FIFO holds 2 entries, FSM in FORCE; pulse `rst_ni` low asynchronously between edges.
  - All outputs are 0 immediately.
  - After release: empty FIFO, NORMAL, no stale writes.
- **Simultaneous push/pop.** Count=1, idle pipeline, push at the same edge as head pop. Count stays 1 and the new entry is written the next cycle.
